// File: rtl/seq_detect_skip.sv
// Serial pattern detector: hit pulse one clock after the last pattern bit, then a SKIP_N-sample skip window.
// Hit counter saturates. Gaps in in_valid stall everything. Build with SEQDET_OVF_FLAG_EN to get the sticky ovf flag.
module seq_detect_skip #(
    parameter int               PAT_W   = 3,
    parameter logic [PAT_W-1:0] PATTERN = 3'b010,
    parameter int               SKIP_N  = 8,
    parameter int               CNT_W   = 10,
    parameter int               OVERLAP = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             x,
    input  logic             cnt_clr,
    output logic             hit,
    output logic             skipping,
    output logic [CNT_W-1:0] hit_count
`ifdef SEQDET_OVF_FLAG_EN
    ,
    output logic             ovf
`endif
);

    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam int SK_W   = 8;

    typedef enum logic {HUNT, SKIP} state_t;

    state_t             state, state_n;
    logic [PAT_W-1:0]   shreg, shreg_n, shreg_sh;
    logic [FILL_W-1:0]  fill, fill_n, fill_inc;
    logic [SK_W-1:0]    skip_cnt, skip_n;
    logic [CNT_W-1:0]   cnt_n;
    logic               match;

    generate
        if (PAT_W == 1) begin : g_sh1
            assign shreg_sh = x;
        end else begin : g_shn
            assign shreg_sh = {shreg[PAT_W-2:0], x};
        end
    endgenerate

    assign fill_inc = (fill == FILL_W'(PAT_W)) ? fill : fill + 1'b1;
    assign skipping = (state == SKIP);

    always_comb begin
        state_n = state;
        shreg_n = shreg;
        fill_n  = fill;
        skip_n  = skip_cnt;
        match   = 1'b0;
        if (in_valid) begin
            case (state)
                HUNT: begin
                    shreg_n = shreg_sh;
                    fill_n  = fill_inc;
                    // fill gates matching so stale bits left over from a skip never complete a pattern
                    if (fill_inc == FILL_W'(PAT_W) && shreg_sh == PATTERN) begin
                        match = 1'b1;
                        if (SKIP_N > 0) begin
                            state_n = SKIP;
                            skip_n  = '0;
                            fill_n  = '0;
                        end else begin
                            fill_n = (OVERLAP != 0) ? FILL_W'(PAT_W) : '0;
                        end
                    end
                end
                SKIP: begin
                    if (skip_cnt == SK_W'(SKIP_N - 1)) begin
                        state_n = HUNT;
                        skip_n  = '0;
                        fill_n  = '0;
                    end else begin
                        skip_n = skip_cnt + 1'b1;
                    end
                end
                default: state_n = HUNT;
            endcase
        end
    end

    // A hit on the same edge as cnt_clr wins: the count restarts at 1.
    always_comb begin
        cnt_n = hit_count;
        if (match) begin
            if (cnt_clr)
                cnt_n = CNT_W'(1);
            else if (hit_count != {CNT_W{1'b1}})
                cnt_n = hit_count + 1'b1;
        end else if (cnt_clr) begin
            cnt_n = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= HUNT;
            shreg     <= '0;
            fill      <= '0;
            skip_cnt  <= '0;
            hit       <= 1'b0;
            hit_count <= '0;
        end else begin
            state     <= state_n;
            shreg     <= shreg_n;
            fill      <= fill_n;
            skip_cnt  <= skip_n;
            hit       <= match;
            hit_count <= cnt_n;
        end
    end

`ifdef SEQDET_OVF_FLAG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ovf <= 1'b0;
        else if (cnt_clr)
            ovf <= 1'b0;
        else if (match && hit_count == {CNT_W{1'b1}})
            ovf <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_seq_detect_skip.sv
// Directed bench for seq_detect_skip: default instance driven from a vector table,
// plus SKIP_N=0 overlap/non-overlap instances and a CNT_W=2 saturation instance.
module tb_seq_detect_skip;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic v0 = 0, x0 = 0, c0 = 0;
    logic v12 = 0, x12 = 0, c12 = 0;
    logic v3 = 0, x3 = 0, c3 = 0;
    logic h0, s0, h1, s1, h2, s2, h3, s3;
    logic [9:0] n0, n1, n2;
    logic [1:0] n3;
`ifdef SEQDET_OVF_FLAG_EN
    logic o0, o1, o2, o3;
`endif

    seq_detect_skip u_dut (.clk(clk), .rst(rst), .in_valid(v0), .x(x0), .cnt_clr(c0),
        .hit(h0), .skipping(s0), .hit_count(n0)
`ifdef SEQDET_OVF_FLAG_EN
        , .ovf(o0)
`endif
    );
    seq_detect_skip #(.SKIP_N(0), .OVERLAP(1)) u_ov1 (.clk(clk), .rst(rst), .in_valid(v12),
        .x(x12), .cnt_clr(c12), .hit(h1), .skipping(s1), .hit_count(n1)
`ifdef SEQDET_OVF_FLAG_EN
        , .ovf(o1)
`endif
    );
    seq_detect_skip #(.SKIP_N(0), .OVERLAP(0)) u_ov0 (.clk(clk), .rst(rst), .in_valid(v12),
        .x(x12), .cnt_clr(c12), .hit(h2), .skipping(s2), .hit_count(n2)
`ifdef SEQDET_OVF_FLAG_EN
        , .ovf(o2)
`endif
    );
    seq_detect_skip #(.SKIP_N(2), .CNT_W(2)) u_sat (.clk(clk), .rst(rst), .in_valid(v3),
        .x(x3), .cnt_clr(c3), .hit(h3), .skipping(s3), .hit_count(n3)
`ifdef SEQDET_OVF_FLAG_EN
        , .ovf(o3)
`endif
    );

    typedef struct {
        logic v;
        logic x;
        logic clr;
        logic e_hit;
        logic e_skip;
        int   e_cnt;
    } vec_t;

    vec_t tbl[$];
    int   n_chk = 0;
    int   n_err = 0;

    function automatic void add(logic v, logic xb, logic clr, logic eh, logic es, int ec);
        vec_t r;
        r.v = v; r.x = xb; r.clr = clr; r.e_hit = eh; r.e_skip = es; r.e_cnt = ec;
        tbl.push_back(r);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic run(input int a, input int b);
        for (int i = a; i < b; i++) begin
            v0 = tbl[i].v; x0 = tbl[i].x; c0 = tbl[i].clr;
            @(posedge clk); #1;
            chk($sformatf("row%0d_hit", i), 32'(h0), 32'(tbl[i].e_hit));
            chk($sformatf("row%0d_skip", i), 32'(s0), 32'(tbl[i].e_skip));
            chk($sformatf("row%0d_cnt", i), 32'(n0), 32'(tbl[i].e_cnt));
        end
        v0 = 0; c0 = 0;
    endtask

    task automatic step3(input logic xb, input logic clr);
        v3 = 1; x3 = xb; c3 = clr;
        @(posedge clk); #1;
        v3 = 0; c3 = 0;
    endtask

    logic [4:0] ov_x   = 5'b01010;
    logic [4:0] ov1_eh = 5'b00101;
    logic [4:0] ov0_eh = 5'b00100;
    int idx_rst;
    int idx_end;

    initial begin
        // 0,1,0 -> hit one clock after the third bit
        add(1,0,0, 0,0,0); add(1,1,0, 0,0,0); add(1,0,0, 1,1,1);
        // eight discarded samples, then a fresh 0,1,0
        add(1,0,0, 0,1,1); add(1,1,0, 0,1,1); add(1,0,0, 0,1,1); add(1,0,0, 0,1,1);
        add(1,1,0, 0,1,1); add(1,0,0, 0,1,1); add(1,0,0, 0,1,1); add(1,1,0, 0,0,1);
        add(1,0,0, 0,0,1); add(1,1,0, 0,0,1); add(1,0,0, 1,1,2);
        // skip window with gaps: only valid samples count
        add(1,1,0, 0,1,2); add(0,0,0, 0,1,2); add(1,1,0, 0,1,2); add(1,1,0, 0,1,2);
        add(0,0,0, 0,1,2); add(0,0,0, 0,1,2); add(1,1,0, 0,1,2); add(1,1,0, 0,1,2);
        add(1,1,0, 0,1,2); add(1,1,0, 0,1,2); add(1,1,0, 0,0,2);
        // 0, three idle cycles, 1, 0 -> single hit
        add(1,0,0, 0,0,2); add(0,1,0, 0,0,2); add(0,1,0, 0,0,2); add(0,1,0, 0,0,2);
        add(1,1,0, 0,0,2); add(1,0,0, 1,1,3);
        add(0,1,0, 0,1,3); add(0,1,1, 0,1,0); add(0,1,0, 0,1,0);
        // three skipped samples before the reset
        add(1,1,0, 0,1,0); add(1,1,0, 0,1,0); add(1,1,0, 0,1,0);
        idx_rst = tbl.size();
        // after reset: 1,0 must not hit even though shreg reads 010
        add(1,1,0, 0,0,0); add(1,0,0, 0,0,0);
        add(1,0,0, 0,0,0); add(1,1,0, 0,0,0); add(1,0,0, 1,1,1);
        idx_end = tbl.size();

        repeat (2) @(posedge clk);
        #1;
        chk("rst_hit", 32'(h0), 0);
        chk("rst_skip", 32'(s0), 0);
        chk("rst_cnt", 32'(n0), 0);
        rst = 0;

        run(0, idx_rst);

        // asynchronous reset mid-cycle while in SKIP
        #2 rst = 1;
        #1;
        chk("arst_skip", 32'(s0), 0);
        chk("arst_cnt", 32'(n0), 0);
        @(posedge clk); #1;
        rst = 0;
        run(idx_rst, idx_end);

        // SKIP_N=0: overlap vs non-overlap on 0,1,0,1,0
        for (int i = 4; i >= 0; i--) begin
            v12 = 1; x12 = ov_x[i];
            @(posedge clk); #1;
            chk($sformatf("ov1_hit%0d", 4 - i), 32'(h1), 32'(ov1_eh[i]));
            chk($sformatf("ov0_hit%0d", 4 - i), 32'(h2), 32'(ov0_eh[i]));
        end
        v12 = 0;
        chk("ov1_cnt", 32'(n1), 2);
        chk("ov0_cnt", 32'(n2), 1);
        chk("ov1_skip", 32'(s1), 0);

        // CNT_W=2 saturation, SKIP_N=2
        for (int k = 0; k < 4; k++) begin
            step3(0, 0); step3(1, 0); step3(0, 0);
            chk($sformatf("sat_hit%0d", k), 32'(h3), 1);
            chk($sformatf("sat_cnt%0d", k), 32'(n3), (k < 3) ? k + 1 : 3);
            chk($sformatf("sat_skip%0d", k), 32'(s3), 1);
`ifdef SEQDET_OVF_FLAG_EN
            chk($sformatf("sat_ovf%0d", k), 32'(o3), (k == 3) ? 1 : 0);
`endif
            step3(1, 0); step3(1, 0);
            chk($sformatf("sat_skipend%0d", k), 32'(s3), 0);
        end
        step3(0, 0); step3(1, 0); step3(0, 1);
        chk("clrhit_hit", 32'(h3), 1);
        chk("clrhit_cnt", 32'(n3), 1);
`ifdef SEQDET_OVF_FLAG_EN
        chk("clrhit_ovf", 32'(o3), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
